// File: rtl/qspi_seq_fsm_pkg.sv
// State encoding and small helpers shared by the QSPI transfer-phase sequencer.
package qspi_fsm_pkg;

    typedef enum logic [3:0] {
        ST_FREE       = 4'h0,
        ST_FINISH     = 4'h1,
        ST_READY      = 4'h2,
        ST_REQ        = 4'h3,
        ST_ADDR       = 4'h4,
        ST_WR_DATA    = 4'h5,
        ST_RD_DUMMY   = 4'h6,
        ST_RD         = 4'h7,
        ST_WR_CSR     = 4'h8,
        ST_CHECK      = 4'h9,
        ST_WAIT_READ  = 4'hA,
        ST_WREN       = 4'hB,
        ST_WAIT_CHECK = 4'hC,
        ST_CHECK_FAIL = 4'hD,
        ST_POLL       = 4'hE,
        ST_START      = 4'hF
    } state_e;

    // States in which the selected flash must see its chip select low.
    function automatic logic csActive(input state_e st);
        return (st == ST_WREN)     || (st == ST_REQ)      || (st == ST_ADDR) ||
               (st == ST_WR_CSR)   || (st == ST_WR_DATA)  || (st == ST_RD_DUMMY) ||
               (st == ST_RD)       || (st == ST_POLL);
    endfunction

endpackage

// File: rtl/qspi_seq_fsm_if.sv
// Request/status bundle between the interface level, the sequencer and the tran level.
interface qspi_seq_fsm_if #(
    parameter int CS_NUM = 2,
    parameter int CS_W   = 1
);
    logic              io_start_signal;
    logic [CS_W-1:0]   io_cs_sel;
    logic              io_interface_lev_wren;
    logic              io_addr_valid;
    logic              io_dummy_valid;
    logic              io_wr_valid;
    logic              io_rd_valid;
    logic              io_erase_valid;
    logic              io_poll_en;
    logic              io_tran_finish;
    logic              io_busy;
    logic              io_check_pass;

    logic [3:0]        io_state;
    logic              io_next_req;
    logic              io_state_wren_way;
    logic              io_state_check_way;
    logic [CS_NUM-1:0] io_cs_n;
    logic [7:0]        io_retry_cnt;
    logic              io_error;
    logic              io_timeout;

    modport master (
        output io_start_signal, io_cs_sel, io_interface_lev_wren, io_addr_valid,
               io_dummy_valid, io_wr_valid, io_rd_valid, io_erase_valid, io_poll_en,
               io_tran_finish, io_busy, io_check_pass,
        input  io_state, io_next_req, io_state_wren_way, io_state_check_way,
               io_cs_n, io_retry_cnt, io_error, io_timeout
    );

    modport slave (
        input  io_start_signal, io_cs_sel, io_interface_lev_wren, io_addr_valid,
               io_dummy_valid, io_wr_valid, io_rd_valid, io_erase_valid, io_poll_en,
               io_tran_finish, io_busy, io_check_pass,
        output io_state, io_next_req, io_state_wren_way, io_state_check_way,
               io_cs_n, io_retry_cnt, io_error, io_timeout
    );

endinterface

// File: rtl/qspi_seq_fsm_sat_counter.sv
// Saturating up-counter with a clear that takes priority over increment.
module qspi_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear wins; increment stops at all-ones so the count never wraps.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !(&count_q)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign value_o = count_q;

endmodule

// File: rtl/qspi_seq_fsm.sv
// Sequences one flash request through INST/ADDR/DUMMY/DATA phases, with WIP polling,
// bounded verify retries with back-off, and chip-select routing.
module qspi_seq_fsm
    import qspi_fsm_pkg::*;
#(
    parameter int CS_NUM    = 2,
    parameter int CS_W      = 1,
    parameter int BACKOFF_W = 8,
    parameter int MAX_RETRY = 3,
    parameter int POLL_MAX  = 1024
) (
    input logic           clock,
    input logic           reset,
    qspi_seq_fsm_if.slave bus
);

    localparam logic [BACKOFF_W-1:0] BACKOFF_LAST = {1'b0, {(BACKOFF_W-1){1'b1}}};

    state_e            state_q, state_d;
    logic [CS_W-1:0]   csSel_q;
    logic [CS_NUM-1:0] csN_q;
    logic [CS_NUM-1:0] csOneHot;
    logic              wrenWay_q, checkWay_q, error_q, timeout_q;

    logic [15:0]          pollCnt;
    logic [7:0]           retryCnt;
    logic [BACKOFF_W-1:0] backoffCnt;

    logic fin;
    logic clrReq;
    logic pollHit;
    logic retryMax;
    logic backoffDone;
    logic pollInc;
    logic retryInc;
    logic setError;
    logic setTimeout;

    assign fin         = bus.io_tran_finish;
    assign pollHit     = (17'(pollCnt) + 17'd1) == 17'(POLL_MAX);
    assign retryMax    = retryCnt == 8'(MAX_RETRY);
    assign backoffDone = backoffCnt == BACKOFF_LAST;
    assign clrReq      = (state_d == ST_FREE) || (state_d == ST_START);

    // Next-state decode plus the one-shot events that feed the counters and status flags.
    always_comb begin
        state_d    = state_q;
        pollInc    = 1'b0;
        retryInc   = 1'b0;
        setError   = 1'b0;
        setTimeout = 1'b0;
        case (state_q)
            ST_FREE:       if (bus.io_start_signal) state_d = ST_START;
            ST_START:      state_d = ST_READY;
            ST_READY: begin
                if (fin) begin
                    if (((bus.io_wr_valid && bus.io_interface_lev_wren) || bus.io_erase_valid)
                        && !wrenWay_q) begin
                        state_d = ST_WREN;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_WREN:       if (fin) state_d = ST_READY;
            ST_REQ: begin
                if (fin) begin
                    if (checkWay_q)              state_d = ST_RD;
                    else if (bus.io_addr_valid)  state_d = ST_ADDR;
                    else if (bus.io_wr_valid)    state_d = ST_WR_CSR;
                    else if (bus.io_dummy_valid) state_d = ST_RD_DUMMY;
                    else if (bus.io_rd_valid)    state_d = ST_RD;
                    else                         state_d = ST_FINISH;
                end
            end
            ST_ADDR: begin
                if (fin) begin
                    if (bus.io_rd_valid)      state_d = ST_RD_DUMMY;
                    else if (bus.io_wr_valid) state_d = ST_WR_DATA;
                    else                      state_d = ST_FINISH;
                end
            end
            ST_WR_CSR:     if (fin) state_d = ST_FINISH;
            ST_RD_DUMMY:   if (fin) state_d = ST_RD;
            ST_WR_DATA:    if (fin) state_d = bus.io_poll_en ? ST_POLL : ST_READY;
            ST_POLL: begin
                if (fin) begin
                    pollInc = 1'b1;
                    if (!bus.io_busy) begin
                        state_d = ST_READY;
                    end else if (pollHit) begin
                        state_d    = ST_FINISH;
                        setTimeout = 1'b1;
                    end
                end
            end
            ST_RD:         if (fin) state_d = checkWay_q ? ST_WAIT_CHECK : ST_WAIT_READ;
            ST_WAIT_READ:  state_d = ST_FINISH;
            ST_WAIT_CHECK: state_d = ST_CHECK;
            ST_CHECK: begin
                if (bus.io_check_pass) begin
                    state_d = ST_FINISH;
                end else if (retryMax) begin
                    state_d  = ST_FINISH;
                    setError = 1'b1;
                end else begin
                    state_d  = ST_CHECK_FAIL;
                    retryInc = 1'b1;
                end
            end
            ST_CHECK_FAIL: if (backoffDone) state_d = ST_READY;
            ST_FINISH:     state_d = ST_FREE;
            default:       state_d = ST_FREE;
        endcase
    end

    qspi_sat_counter #(.WIDTH(16)) u_pollCnt (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (clrReq),
        .inc_i   (pollInc),
        .value_o (pollCnt)
    );

    qspi_sat_counter #(.WIDTH(8)) u_retryCnt (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (clrReq),
        .inc_i   (retryInc),
        .value_o (retryCnt)
    );

    // The back-off count is cleared on the edge that leaves CHECK_FAIL, so the
    // state exits exactly when the MSB would have set and the count reads zero elsewhere.
    qspi_sat_counter #(.WIDTH(BACKOFF_W)) u_backoff (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (state_d != ST_CHECK_FAIL),
        .inc_i   (state_q == ST_CHECK_FAIL),
        .value_o (backoffCnt)
    );

    // Decode the latched chip-select index into a one-hot vector.
    always_comb begin
        csOneHot = '0;
        for (int i = 0; i < CS_NUM; i++) begin
            csOneHot[i] = (int'(csSel_q) == i);
        end
    end

    // State register, request flags, latched chip select and the registered cs_n drive.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_FREE;
            csSel_q    <= '0;
            csN_q      <= '1;
            wrenWay_q  <= 1'b0;
            checkWay_q <= 1'b0;
            error_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_FREE && bus.io_start_signal) begin
                csSel_q <= (int'(bus.io_cs_sel) < CS_NUM) ? bus.io_cs_sel : '0;
            end
            csN_q <= csActive(state_q) ? ~csOneHot : '1;
            if (clrReq) begin
                wrenWay_q <= 1'b0;
            end else if (state_d == ST_WREN) begin
                wrenWay_q <= 1'b1;
            end
            if (clrReq) begin
                checkWay_q <= 1'b0;
            end else if (state_q == ST_WR_DATA && fin) begin
                checkWay_q <= 1'b1;
            end
            if (state_d == ST_FREE) begin
                error_q   <= 1'b0;
                timeout_q <= 1'b0;
            end else begin
                if (setError)   error_q   <= 1'b1;
                if (setTimeout) timeout_q <= 1'b1;
            end
        end
    end

    assign bus.io_state           = state_q;
    assign bus.io_next_req        = (state_q == ST_FINISH);
    assign bus.io_state_wren_way  = wrenWay_q;
    assign bus.io_state_check_way = checkWay_q;
    assign bus.io_cs_n            = csN_q;
    assign bus.io_retry_cnt       = retryCnt;
    assign bus.io_error           = error_q;
    assign bus.io_timeout         = timeout_q;

endmodule

// File: tb/tb_qspi_seq_fsm.sv
// Directed scenario bench for the QSPI transfer-phase sequencer.
module tb_qspi_seq_fsm;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    qspi_seq_fsm_if #(.CS_NUM(2), .CS_W(1)) bus ();

    qspi_seq_fsm #(
        .CS_NUM(2), .CS_W(1), .BACKOFF_W(8), .MAX_RETRY(3), .POLL_MAX(4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Safety net so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Expected chip-select drive for a given (previous) state and selected flash.
    function automatic logic [1:0] csModel(input logic [3:0] st, input logic sel);
        logic act;
        act = (st == 4'hB) || (st == 4'h3) || (st == 4'h4) || (st == 4'h8) ||
              (st == 4'h5) || (st == 4'h6) || (st == 4'h7) || (st == 4'hE);
        return act ? (sel ? 2'b01 : 2'b10) : 2'b11;
    endfunction

    // Apply one cycle of tran-level response, ending at the next falling edge.
    task automatic drive(input logic f, input logic b, input logic p);
        bus.io_tran_finish = f;
        bus.io_busy        = b;
        bus.io_check_pass  = p;
        @(negedge clock);
        bus.io_tran_finish = 1'b0;
    endtask

    // Set the request descriptor.
    task automatic setReq(input logic sel, input logic lev, input logic addr, input logic dummy,
                          input logic wr, input logic rd, input logic erase, input logic poll);
        bus.io_cs_sel             = sel;
        bus.io_interface_lev_wren = lev;
        bus.io_addr_valid         = addr;
        bus.io_dummy_valid        = dummy;
        bus.io_wr_valid           = wr;
        bus.io_rd_valid           = rd;
        bus.io_erase_valid        = erase;
        bus.io_poll_en            = poll;
    endtask

    // Pulse start for one cycle from FREE.
    task automatic startReq();
        bus.io_start_signal = 1'b1;
        @(negedge clock);
        bus.io_start_signal = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        checks++;
        if (bus.io_state !== 4'h0) begin
            errors++; $display("[TB] FAIL reset_state got=%h exp=0", bus.io_state);
        end
        checks++;
        if (bus.io_cs_n !== 2'b11) begin
            errors++; $display("[TB] FAIL reset_cs_n got=%b exp=11", bus.io_cs_n);
        end
        checks++;
        if (bus.io_next_req !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_next_req got=%b exp=0", bus.io_next_req);
        end
        checks++;
        if (bus.io_retry_cnt !== 8'd0) begin
            errors++; $display("[TB] FAIL reset_retry got=%0d exp=0", bus.io_retry_cnt);
        end
        checks++;
        if ({bus.io_state_wren_way, bus.io_state_check_way, bus.io_error, bus.io_timeout} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_flags got=%b exp=0000",
                {bus.io_state_wren_way, bus.io_state_check_way, bus.io_error, bus.io_timeout});
        end
    endtask

    // Read with address and dummy phases; start is held high mid-request and must be ignored.
    task automatic test_read();
        logic       finV [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] expS [8] = '{4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'hA, 4'h1, 4'h0};
        logic [3:0] prev;
        setReq(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        startReq();
        checks++;
        if (bus.io_state !== 4'hF) begin
            errors++; $display("[TB] FAIL read_start got=%h exp=F", bus.io_state);
        end
        prev = 4'hF;
        for (int i = 0; i < 8; i++) begin
            bus.io_start_signal = (i < 5);
            drive(finV[i], 1'b0, 1'b0);
            checks++;
            if (bus.io_state !== expS[i]) begin
                errors++; $display("[TB] FAIL read_state[%0d] got=%h exp=%h", i, bus.io_state, expS[i]);
            end
            checks++;
            if (bus.io_cs_n !== csModel(prev, 1'b0)) begin
                errors++; $display("[TB] FAIL read_cs_n[%0d] got=%b exp=%b", i, bus.io_cs_n, csModel(prev, 1'b0));
            end
            checks++;
            if (bus.io_next_req !== (expS[i] == 4'h1)) begin
                errors++; $display("[TB] FAIL read_next_req[%0d] got=%b", i, bus.io_next_req);
            end
            prev = expS[i];
        end
        bus.io_start_signal = 1'b0;
    endtask

    // Page program with WREN prefix, WIP polling and a passing re-verify read.
    task automatic test_page_program();
        logic       finV [17] = '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,0,0,0};
        logic       busV [17] = '{0,0,0,0,0,0,0,1,1,1,0,0,0,0,0,0,0};
        logic [3:0] expS [17] = '{4'h2, 4'hB, 4'h2, 4'h3, 4'h4, 4'h5, 4'hE, 4'hE, 4'hE,
                                  4'hE, 4'h2, 4'h3, 4'h7, 4'hC, 4'h9, 4'h1, 4'h0};
        logic [3:0] prev;
        setReq(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        startReq();
        prev = 4'hF;
        for (int i = 0; i < 17; i++) begin
            drive(finV[i], busV[i], 1'b1);
            checks++;
            if (bus.io_state !== expS[i]) begin
                errors++; $display("[TB] FAIL pp_state[%0d] got=%h exp=%h", i, bus.io_state, expS[i]);
            end
            checks++;
            if (bus.io_cs_n !== csModel(prev, 1'b0)) begin
                errors++; $display("[TB] FAIL pp_cs_n[%0d] got=%b exp=%b", i, bus.io_cs_n, csModel(prev, 1'b0));
            end
            if (i == 1) begin
                checks++;
                if (bus.io_state_wren_way !== 1'b1) begin
                    errors++; $display("[TB] FAIL pp_wren_way got=%b exp=1", bus.io_state_wren_way);
                end
            end
            if (i == 6) begin
                checks++;
                if (bus.io_state_check_way !== 1'b1) begin
                    errors++; $display("[TB] FAIL pp_check_way got=%b exp=1", bus.io_state_check_way);
                end
            end
            if (i == 15) begin
                checks++;
                if ({bus.io_next_req, bus.io_timeout, bus.io_error, bus.io_retry_cnt} !== {3'b100, 8'd0}) begin
                    errors++; $display("[TB] FAIL pp_finish got next=%b to=%b err=%b retry=%0d exp 1/0/0/0",
                        bus.io_next_req, bus.io_timeout, bus.io_error, bus.io_retry_cnt);
                end
            end
            prev = expS[i];
        end
    endtask

    // Verify fails four times: three 128-cycle back-offs, then FINISH with io_error.
    task automatic test_verify_retry();
        logic       finV [9] = '{0,1,1,1,1,1,1,1,0};
        logic [3:0] expS [9] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h2, 4'h3, 4'h7, 4'hC, 4'h9};
        int n;
        setReq(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        startReq();
        for (int i = 0; i < 9; i++) begin
            drive(finV[i], 1'b0, 1'b0);
            checks++;
            if (bus.io_state !== expS[i]) begin
                errors++; $display("[TB] FAIL vr_prefix[%0d] got=%h exp=%h", i, bus.io_state, expS[i]);
            end
        end
        for (int a = 1; a <= 3; a++) begin
            drive(1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.io_state !== 4'hD || bus.io_retry_cnt !== 8'(a)) begin
                errors++; $display("[TB] FAIL vr_fail%0d got state=%h retry=%0d exp D/%0d",
                    a, bus.io_state, bus.io_retry_cnt, a);
            end
            n = 1;
            for (int k = 0; k < 300; k++) begin
                drive(1'b0, 1'b0, 1'b0);
                if (bus.io_state != 4'hD) break;
                n++;
            end
            checks++;
            if (n !== 128 || bus.io_state !== 4'h2) begin
                errors++; $display("[TB] FAIL vr_backoff%0d got cycles=%0d state=%h exp 128/2", a, n, bus.io_state);
            end
            drive(1'b1, 1'b0, 1'b0);
            drive(1'b1, 1'b0, 1'b0);
            drive(1'b1, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.io_state !== 4'h9) begin
                errors++; $display("[TB] FAIL vr_reverify%0d got=%h exp=9", a, bus.io_state);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.io_state, bus.io_next_req, bus.io_error, bus.io_retry_cnt} !== {4'h1, 2'b11, 8'd3}) begin
            errors++; $display("[TB] FAIL vr_error got state=%h next=%b err=%b retry=%0d exp 1/1/1/3",
                bus.io_state, bus.io_next_req, bus.io_error, bus.io_retry_cnt);
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.io_state, bus.io_error, bus.io_retry_cnt} !== {4'h0, 1'b0, 8'd0}) begin
            errors++; $display("[TB] FAIL vr_free got state=%h err=%b retry=%0d exp 0/0/0",
                bus.io_state, bus.io_error, bus.io_retry_cnt);
        end
    endtask

    // Busy stuck high: the 4th poll ends the request with io_timeout; the next read is clean.
    task automatic test_poll_timeout();
        logic       finV [5] = '{0,1,1,1,1};
        logic [3:0] expS [5] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'hE};
        setReq(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        startReq();
        for (int i = 0; i < 5; i++) begin
            drive(finV[i], 1'b0, 1'b0);
            checks++;
            if (bus.io_state !== expS[i]) begin
                errors++; $display("[TB] FAIL to_prefix[%0d] got=%h exp=%h", i, bus.io_state, expS[i]);
            end
        end
        for (int p = 1; p <= 3; p++) begin
            drive(1'b1, 1'b1, 1'b0);
            checks++;
            if (bus.io_state !== 4'hE || bus.io_timeout !== 1'b0) begin
                errors++; $display("[TB] FAIL to_poll%0d got state=%h to=%b exp E/0", p, bus.io_state, bus.io_timeout);
            end
        end
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if ({bus.io_state, bus.io_timeout, bus.io_next_req} !== {4'h1, 2'b11}) begin
            errors++; $display("[TB] FAIL to_finish got state=%h to=%b next=%b exp 1/1/1",
                bus.io_state, bus.io_timeout, bus.io_next_req);
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.io_state, bus.io_timeout, bus.io_state_check_way} !== {4'h0, 2'b00}) begin
            errors++; $display("[TB] FAIL to_free got state=%h to=%b cw=%b exp 0/0/0",
                bus.io_state, bus.io_timeout, bus.io_state_check_way);
        end
        setReq(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        startReq();
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.io_state !== 4'h7) begin
            errors++; $display("[TB] FAIL to_clean_rd got=%h exp=7", bus.io_state);
        end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.io_state, bus.io_timeout, bus.io_error} !== {4'h1, 2'b00}) begin
            errors++; $display("[TB] FAIL to_clean_finish got state=%h to=%b err=%b exp 1/0/0",
                bus.io_state, bus.io_timeout, bus.io_error);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    // Sector erase then a register write, both on chip select 1, each with a single WREN.
    task automatic test_erase_cs1();
        logic       finV [7] = '{0,1,1,1,1,1,0};
        logic [3:0] expS [2][7] = '{'{4'h2, 4'hB, 4'h2, 4'h3, 4'h4, 4'h1, 4'h0},
                                    '{4'h2, 4'hB, 4'h2, 4'h3, 4'h8, 4'h1, 4'h0}};
        logic [3:0] prev;
        for (int r = 0; r < 2; r++) begin
            if (r == 0) setReq(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            else        setReq(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            startReq();
            prev = 4'hF;
            for (int i = 0; i < 7; i++) begin
                drive(finV[i], 1'b0, 1'b0);
                checks++;
                if (bus.io_state !== expS[r][i]) begin
                    errors++; $display("[TB] FAIL cs1_state[%0d][%0d] got=%h exp=%h", r, i, bus.io_state, expS[r][i]);
                end
                checks++;
                if (bus.io_cs_n !== csModel(prev, 1'b1)) begin
                    errors++; $display("[TB] FAIL cs1_cs_n[%0d][%0d] got=%b exp=%b", r, i, bus.io_cs_n, csModel(prev, 1'b1));
                end
                prev = expS[r][i];
            end
        end
    endtask

    // Reset asserted in POLL and in CHECK_FAIL aborts cleanly, and a later back-off is full length.
    task automatic test_reset_midflight();
        int n;
        setReq(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        startReq();
        drive(1'b0, 1'b0, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.io_state !== 4'hE) begin
            errors++; $display("[TB] FAIL rst_poll_pre got=%h exp=E", bus.io_state);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({bus.io_state, bus.io_cs_n, bus.io_next_req, bus.io_state_check_way, bus.io_retry_cnt}
            !== {4'h0, 2'b11, 2'b00, 8'd0}) begin
            errors++; $display("[TB] FAIL rst_poll got state=%h cs=%b next=%b cw=%b exp 0/11/0/0",
                bus.io_state, bus.io_cs_n, bus.io_next_req, bus.io_state_check_way);
        end
        setReq(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int pass = 0; pass < 2; pass++) begin
            startReq();
            drive(1'b0, 1'b0, 1'b0);
            repeat (7) drive(1'b1, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.io_state !== 4'hD) begin
                errors++; $display("[TB] FAIL rst_cf_pre%0d got=%h exp=D", pass, bus.io_state);
            end
            if (pass == 0) begin
                repeat (10) drive(1'b0, 1'b0, 1'b0);
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                checks++;
                if ({bus.io_state, bus.io_cs_n, bus.io_next_req, bus.io_retry_cnt} !== {4'h0, 2'b11, 1'b0, 8'd0}) begin
                    errors++; $display("[TB] FAIL rst_cf got state=%h cs=%b next=%b retry=%0d exp 0/11/0/0",
                        bus.io_state, bus.io_cs_n, bus.io_next_req, bus.io_retry_cnt);
                end
                drive(1'b0, 1'b0, 1'b0);
                checks++;
                if (bus.io_next_req !== 1'b0 || bus.io_state !== 4'h0) begin
                    errors++; $display("[TB] FAIL rst_cf_after got state=%h next=%b exp 0/0", bus.io_state, bus.io_next_req);
                end
            end else begin
                n = 1;
                for (int k = 0; k < 300; k++) begin
                    drive(1'b0, 1'b0, 1'b0);
                    if (bus.io_state != 4'hD) break;
                    n++;
                end
                checks++;
                if (n !== 128 || bus.io_retry_cnt !== 8'd1) begin
                    errors++; $display("[TB] FAIL rst_cf_backoff got cycles=%0d retry=%0d exp 128/1", n, bus.io_retry_cnt);
                end
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        bus.io_start_signal = 1'b0;
        bus.io_tran_finish  = 1'b0;
        bus.io_busy         = 1'b0;
        bus.io_check_pass   = 1'b0;
        setReq(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_read();
        test_page_program();
        test_verify_retry();
        test_poll_timeout();
        test_erase_cs1();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
